// File: rtl/ps2_key_ctrl_pkg.sv
// rtl/ps2_key_ctrl_pkg.sv - PS/2 scan-code constants, prefix states and event record
package ps2_key_ctrl_pkg;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    typedef enum logic [1:0] {
        ST_BASE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } prefix_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ps2_evt_t;

    localparam int EVT_W = $bits(ps2_evt_t);

endpackage

// File: rtl/ps2_key_ctrl_fifo.sv
// rtl/ps2_key_ctrl_fifo.sv - sync event FIFO with registered show-ahead head
module ps2_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             full,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_nxt;
    logic             empty;
    logic             do_pop;
    logic             do_push;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign overflow = push & full & ~do_pop;
    assign valid    = ~empty;
    assign head     = head_q;

    // The head register is loaded with whatever will be at the read pointer
    // after this edge, bypassing memory when the pushed word becomes head.
    always_comb begin
        head_nxt = head_q;
        if (do_pop) begin
            if (count > CW'(1))
                head_nxt = mem[AW'(rd_ptr + 1'b1)];
            else if (do_push)
                head_nxt = push_data;
        end else if (empty && do_push) begin
            head_nxt = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            head_q <= head_nxt;
            if (do_push)
                wr_ptr <= AW'(wr_ptr + 1'b1);
            if (do_pop)
                rd_ptr <= AW'(rd_ptr + 1'b1);
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// rtl/ps2_key_ctrl.sv - folds E0/F0 prefixes into key events and queues them
module ps2_key_ctrl
    import ps2_key_ctrl_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PREFIX_TO = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       rx_en,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_break,
    output logic       evt_ext,
    output logic       err_flag,
    input  logic       err_clr
);

    localparam int CNT_W = $clog2(PREFIX_TO);

    prefix_state_t    state;
    prefix_state_t    state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             timeout;
    logic             push;
    logic             err_byte;
    ps2_evt_t         push_evt;
    ps2_evt_t         head_evt;
    logic [EVT_W-1:0] head_bits;
    logic             fifo_full;
    logic             overflow;

    assign timeout = (state != ST_BASE) && (cnt == CNT_W'(PREFIX_TO - 1));

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        err_byte  = 1'b0;
        push_evt  = '{code: rx_data,
                      brk:  (state == ST_BRK) || (state == ST_EXT_BRK),
                      ext:  (state == ST_EXT) || (state == ST_EXT_BRK)};
        if (rx_done_tick) begin
            case (rx_data)
                PS2_EXT: state_nxt = ST_EXT;
                PS2_BRK: begin
                    if (state == ST_BASE)
                        state_nxt = ST_BRK;
                    else if (state == ST_EXT)
                        state_nxt = ST_EXT_BRK;
                end
                PS2_ERR0, PS2_ERR1: begin
                    err_byte  = 1'b1;
                    state_nxt = ST_BASE;
                end
                default: begin
                    push      = 1'b1;
                    state_nxt = ST_BASE;
                end
            endcase
        end else if (timeout) begin
            state_nxt = ST_BASE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_BASE;
            cnt      <= '0;
            rx_en    <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (rx_done_tick || state == ST_BASE || timeout)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            // Only one frame can be in flight, so gating new starts on full
            // is enough to keep the FIFO from being overrun by the receiver.
            rx_en <= enable & ~fifo_full;
            if (err_byte || overflow)
                err_flag <= 1'b1;
            else if (err_clr)
                err_flag <= 1'b0;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_evt),
        .pop       (evt_ready),
        .head      (head_bits),
        .valid     (evt_valid),
        .full      (fifo_full),
        .overflow  (overflow)
    );

    assign head_evt  = head_bits;
    assign evt_code  = head_evt.code;
    assign evt_break = head_evt.brk;
    assign evt_ext   = head_evt.ext;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb/tb_ps2_key_ctrl.sv - directed self-checking bench for ps2_key_ctrl
module tb_ps2_key_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       rx_en;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_break;
    logic       evt_ext;
    logic       err_flag;
    logic       err_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ps2_key_ctrl #(
        .DEPTH     (4),
        .PREFIX_TO (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rx_en        (rx_en),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_break    (evt_break),
        .evt_ext      (evt_ext),
        .err_flag     (err_flag),
        .err_clr      (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one-cycle rx_done_tick; returns 1ns after the edge that consumed it
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic send_with_pop(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data      = b;
        rx_done_tick = 1'b1;
        evt_ready    = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        evt_ready    = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [7:0] code,
                               input logic brk, input logic ext);
        check({tag, ".valid"}, 32'(evt_valid), 32'd1);
        check({tag, ".code"},  32'(evt_code),  32'(code));
        check({tag, ".brk"},   32'(evt_break), 32'(brk));
        check({tag, ".ext"},   32'(evt_ext),   32'(ext));
    endtask

    task automatic pop_evt(input string tag, input logic [7:0] code,
                           input logic brk, input logic ext);
        expect_head(tag, code, brk, ext);
        evt_ready = 1'b1;
        @(posedge clk); #1;
        evt_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".rx_en"},  32'(rx_en),     32'd0);
        check({tag, ".valid"},  32'(evt_valid), 32'd0);
        check({tag, ".code"},   32'(evt_code),  32'd0);
        check({tag, ".brk"},    32'(evt_break), 32'd0);
        check({tag, ".ext"},    32'(evt_ext),   32'd0);
        check({tag, ".err"},    32'(err_flag),  32'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        enable       = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        evt_ready    = 1'b0;
        err_clr      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rx_en_up", 32'(rx_en), 32'd1);

        // plain make, then break
        send_byte(8'h1C);
        pop_evt("make_1c", 8'h1C, 1'b0, 1'b0);
        check("empty_after_pop", 32'(evt_valid), 32'd0);
        send_byte(8'hF0);
        check("no_evt_on_f0", 32'(evt_valid), 32'd0);
        send_byte(8'h1C);
        pop_evt("brk_1c", 8'h1C, 1'b1, 1'b0);

        // extended prefixes
        send_byte(8'hE0); send_byte(8'h75);
        pop_evt("ext_75", 8'h75, 1'b0, 1'b1);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        pop_evt("ext_brk_75", 8'h75, 1'b1, 1'b1);
        send_byte(8'hE0); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        pop_evt("ext_ext_brk_6b", 8'h6B, 1'b1, 1'b1);

        // fill FIFO with consumer stalled
        send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24); send_byte(8'h2D);
        @(posedge clk); #1;
        check("rx_en_full", 32'(rx_en), 32'd0);
        pop_evt("fifo_0", 8'h15, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("rx_en_back", 32'(rx_en), 32'd1);

        // refill, then push with concurrent pop, then forced overflow
        send_byte(8'h34);
        send_with_pop(8'h3C);
        check("no_err_push_pop", 32'(err_flag), 32'd0);
        send_byte(8'h44);
        check("err_overflow", 32'(err_flag), 32'd1);
        pop_evt("fifo_1", 8'h24, 1'b0, 1'b0);
        pop_evt("fifo_2", 8'h2D, 1'b0, 1'b0);
        pop_evt("fifo_3", 8'h34, 1'b0, 1'b0);
        pop_evt("fifo_4", 8'h3C, 1'b0, 1'b0);
        check("drained", 32'(evt_valid), 32'd0);
        pulse_clr();
        check("err_cleared", 32'(err_flag), 32'd0);

        // prefix timeout (PREFIX_TO=16)
        send_byte(8'hF0);
        repeat (20) @(posedge clk);
        send_byte(8'h1C);
        pop_evt("timeout_1c", 8'h1C, 1'b0, 1'b0);
        send_byte(8'hF0);
        repeat (12) @(posedge clk);
        send_byte(8'h1C);
        pop_evt("in_time_1c", 8'h1C, 1'b1, 1'b0);

        // error bytes and clear precedence
        send_byte(8'hFF);
        check("err_ff", 32'(err_flag), 32'd1);
        check("no_evt_ff", 32'(evt_valid), 32'd0);
        pulse_clr();
        check("err_clr_ff", 32'(err_flag), 32'd0);
        @(posedge clk); #1;
        rx_data      = 8'h00;
        rx_done_tick = 1'b1;
        err_clr      = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        err_clr      = 1'b0;
        check("err_wins_clr", 32'(err_flag), 32'd1);
        check("no_evt_00", 32'(evt_valid), 32'd0);

        // reset in the middle of an E0 F0 prefix with an event queued
        send_byte(8'h5A);
        send_byte(8'hE0);
        send_byte(8'hF0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_byte(8'h1C);
        pop_evt("after_reset", 8'h1C, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
